// File: rtl/cmos_dvp_tx.sv
// Sensor-side DVP transmitter: frames RGB565 pixels from an external source or an
// internal colour-bar generator into the vsync/href/byte stream of an OV-style camera.
module cmos_dvp_tx #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 8,
    parameter int V_FRONT   = 8
) (
    input  logic        clk_cmos,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic        test_mode,
    output logic        pixel_req,
    input  logic [15:0] pixel_din,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_dout,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        busy
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN);
    localparam int VM_A     = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int VM_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX    = (VM_A > VM_B) ? VM_A : VM_B;
    localparam int VW       = $clog2(V_MAX + 1);
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BW       = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_REQ_FIRST = HW'(LINE_LEN - 2);
    localparam logic [HW-1:0] H_REQ_LAST = HW'(2 * H_ACTIVE - 4);
    localparam logic [HW-1:0] H_BYTES    = HW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_e;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic            mode_q, mode_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    logic [BW-1:0]   bar_px_q, bar_px_d;
    logic [7:0]      lo_byte_q, lo_byte_d;

    logic            req_q, req_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      dout_q, dout_d;
    logic            fs_q, fs_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            busy_q, busy_d;

    logic [VW-1:0]   v_last;
    logic            line_end;
    logic            frame_end;

    // Frame sequencing: every state lasts a whole number of lines.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        frame_end = 1'b0;
        line_end  = (h_cnt_q == H_LAST);

        case (state_q)
            ST_VSYNC:  v_last = VW'(VSYNC_LEN - 1);
            ST_VBACK:  v_last = VW'(V_BACK - 1);
            ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            ST_VFRONT: v_last = VW'(V_FRONT - 1);
            default:   v_last = '0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (tx_en) begin
                    state_d = ST_VSYNC;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end
            end
            default: begin
                h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
                if (line_end) begin
                    if (v_cnt_q == v_last) begin
                        v_cnt_d = '0;
                        case (state_q)
                            ST_VSYNC:  state_d = ST_VBACK;
                            ST_VBACK:  state_d = ST_ACTIVE;
                            ST_ACTIVE: state_d = ST_VFRONT;
                            default: begin
                                frame_end = 1'b1;
                                state_d   = tx_en ? ST_VSYNC : ST_IDLE;
                            end
                        endcase
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    logic            frame_enter;
    logic            next_line_active;
    logic            hi_slot;
    logic [2:0]      cur_idx;
    logic [BW-1:0]   cur_px;
    logic [15:0]     pix;

    // Outputs are decoded from the *next* state and counters so that, once
    // registered, they line up with the state/counter values of their own cycle.
    always_comb begin
        frame_enter      = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
        mode_d           = frame_enter ? test_mode : mode_q;
        next_line_active = ((state_d == ST_VBACK) && (v_cnt_d == VW'(V_BACK - 1))) ||
                           ((state_d == ST_ACTIVE) && (v_cnt_d != VW'(V_ACTIVE - 1)));

        href_d  = (state_d == ST_ACTIVE) && (h_cnt_d < H_BYTES);
        hi_slot = href_d && !h_cnt_d[0];

        // Request pixel p two cycles before its high byte; pixel 0 borrows the
        // tail of the preceding line.
        req_d = !mode_d &&
                (((h_cnt_d == H_REQ_FIRST) && next_line_active) ||
                 ((state_d == ST_ACTIVE) && !h_cnt_d[0] && (h_cnt_d <= H_REQ_LAST)));

        cur_idx   = (h_cnt_d == '0) ? 3'd0 : bar_idx_q;
        cur_px    = (h_cnt_d == '0) ? '0   : bar_px_q;
        bar_idx_d = bar_idx_q;
        bar_px_d  = bar_px_q;
        if (hi_slot) begin
            if (cur_px == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = cur_idx + 3'd1;
            end else begin
                bar_px_d  = cur_px + 1'b1;
                bar_idx_d = cur_idx;
            end
        end

        pix       = mode_d ? bar_colour(cur_idx) : pixel_din;
        lo_byte_d = hi_slot ? pix[7:0] : lo_byte_q;
        if (!href_d) begin
            dout_d = 8'h00;
        end else if (hi_slot) begin
            dout_d = pix[15:8];
        end else begin
            dout_d = lo_byte_q;
        end

        vsync_d = (state_d == ST_VSYNC);
        fs_d    = frame_enter;
        fcnt_d  = frame_end ? fcnt_q + 8'd1 : fcnt_q;
        busy_d  = (state_d != ST_IDLE);
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_cmos or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            mode_q    <= 1'b0;
            bar_idx_q <= '0;
            bar_px_q  <= '0;
            lo_byte_q <= '0;
            req_q     <= 1'b0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            dout_q    <= '0;
            fs_q      <= 1'b0;
            fcnt_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            mode_q    <= mode_d;
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
            lo_byte_q <= lo_byte_d;
            req_q     <= req_d;
            vsync_q   <= vsync_d;
            href_q    <= href_d;
            dout_q    <= dout_d;
            fs_q      <= fs_d;
            fcnt_q    <= fcnt_d;
            busy_q    <= busy_d;
        end
    end

    assign pixel_req   = req_q;
    assign cmos_vsync  = vsync_q;
    assign cmos_href   = href_q;
    assign cmos_dout   = dout_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Bench for cmos_dvp_tx: a table of frame scenarios plus hand-written sequences for
// mid-frame tx_en drop and mid-line reset; emitted bytes are checked against a queue.
module tb_cmos_dvp_tx;

    localparam int H_ACTIVE  = 8;
    localparam int H_BLANK   = 6;
    localparam int V_ACTIVE  = 3;
    localparam int VSYNC_LEN = 1;
    localparam int V_BACK    = 1;
    localparam int V_FRONT   = 1;
    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LEN = (VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT) * LINE_LEN;

    logic        clk_cmos = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic        test_mode;
    logic        pixel_req;
    logic [15:0] pixel_din;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_dout;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic        busy;

    always #5 clk_cmos = ~clk_cmos;

    cmos_dvp_tx #(
        .H_ACTIVE  (H_ACTIVE),
        .H_BLANK   (H_BLANK),
        .V_ACTIVE  (V_ACTIVE),
        .VSYNC_LEN (VSYNC_LEN),
        .V_BACK    (V_BACK),
        .V_FRONT   (V_FRONT)
    ) dut (
        .clk_cmos    (clk_cmos),
        .rst_n       (rst_n),
        .tx_en       (tx_en),
        .test_mode   (test_mode),
        .pixel_req   (pixel_req),
        .pixel_din   (pixel_din),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_dout   (cmos_dout),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    typedef struct {
        logic tm;
        int   frames;
        int   exp_req;
        int   exp_href;
        int   exp_vsync;
    } vec_t;

    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp_q [$];
    int req_total    = 0;
    int href_rises   = 0;
    int vsync_cycles = 0;
    int fs_count     = 0;
    int fs_prev      = 0;
    int fs_last      = 0;
    int cyc          = 0;

    // External pixel source, scoreboard producer and output monitor in one process.
    initial begin : src_mon
        logic       pend;
        logic       href_prev;
        int         src_idx;
        int         href_run;
        logic [7:0] exp_b;
        logic [15:0] c;
        pend      = 1'b0;
        href_prev = 1'b0;
        src_idx   = 0;
        href_run  = 0;
        pixel_din = 16'h0000;
        forever begin
            @(posedge clk_cmos);
            #1;
            if (!rst_n) begin
                pend    = 1'b0;
                src_idx = 0;
                exp_q.delete();
            end else if (pend) begin
                pixel_din = 16'hA000 + 16'(src_idx);
                exp_q.push_back(8'hA0);
                exp_q.push_back(8'(src_idx));
                src_idx = (src_idx + 1) % H_ACTIVE;
                pend    = 1'b0;
            end

            @(negedge clk_cmos);
            cyc++;
            if (!rst_n) begin
                href_run  = 0;
                href_prev = 1'b0;
                pend      = 1'b0;
                src_idx   = 0;
                exp_q.delete();
            end else begin
                check("href_during_vsync", 32'(cmos_href & cmos_vsync), 0);
                if (cmos_href) begin
                    if (exp_q.size() == 0) begin
                        check("byte_without_pixel", 32'(exp_q.size()), 1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("dout_byte", 32'(cmos_dout), 32'(exp_b));
                    end
                    href_run++;
                end else begin
                    check("dout_zero_blank", 32'(cmos_dout), 0);
                    if (href_run != 0) begin
                        check("href_len", href_run, 2 * H_ACTIVE);
                        href_run = 0;
                    end
                end
                if (cmos_href && !href_prev) href_rises++;
                href_prev = cmos_href;
                if (cmos_vsync) vsync_cycles++;
                if (pixel_req) begin
                    req_total++;
                    pend = 1'b1;
                end
                if (frame_start) begin
                    fs_count++;
                    fs_prev = fs_last;
                    fs_last = cyc;
                    if (test_mode) begin
                        for (int l = 0; l < V_ACTIVE; l++) begin
                            for (int p = 0; p < H_ACTIVE; p++) begin
                                c = bar_tab[p / (H_ACTIVE / 8)];
                                exp_q.push_back(c[15:8]);
                                exp_q.push_back(c[7:0]);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int r0, h0, vs0, f0;
        logic [7:0] fc0;
        @(negedge clk_cmos);
        r0  = req_total;
        h0  = href_rises;
        vs0 = vsync_cycles;
        f0  = fs_count;
        fc0 = frame_cnt;
        check("busy_before_start", 32'(busy), 0);
        test_mode = v.tm;
        tx_en     = 1'b1;
        @(negedge clk_cmos);
        check("first_vsync", 32'(cmos_vsync), 1);
        check("first_frame_start", 32'(frame_start), 1);
        for (int f = 1; f <= v.frames; f++) begin
            if (f == v.frames) begin
                repeat (FRAME_LEN - 11) @(negedge clk_cmos);
                tx_en = 1'b0;
                repeat (10) @(negedge clk_cmos);
            end else begin
                repeat (FRAME_LEN - 1) @(negedge clk_cmos);
            end
            check("fcnt_last_cycle", 32'(frame_cnt), 32'(8'(fc0 + 8'(f - 1))));
            @(negedge clk_cmos);
            check("fcnt_after_frame", 32'(frame_cnt), 32'(8'(fc0 + 8'(f))));
            if (f < v.frames) begin
                check("b2b_vsync", 32'(cmos_vsync), 1);
                check("b2b_frame_start", 32'(frame_start), 1);
            end else begin
                check("end_busy", 32'(busy), 0);
                check("end_vsync", 32'(cmos_vsync), 0);
            end
        end
        repeat (10) @(negedge clk_cmos);
        check("req_count", req_total - r0, v.exp_req);
        check("href_pulses", href_rises - h0, v.exp_href);
        check("vsync_cycles", vsync_cycles - vs0, v.exp_vsync);
        check("frame_starts", fs_count - f0, v.frames);
        check("bytes_left", 32'(exp_q.size()), 0);
        if (v.frames > 1) check("fs_spacing", fs_last - fs_prev, FRAME_LEN);
    endtask

    initial begin : stim
        vec_t vecs[4];
        int   r0, h0, vs0;
        logic [7:0] fc0;
        int   waited;

        vecs[0] = '{tm: 1'b0, frames: 1, exp_req: 24, exp_href: 3, exp_vsync: 22};
        vecs[1] = '{tm: 1'b1, frames: 1, exp_req: 0,  exp_href: 3, exp_vsync: 22};
        vecs[2] = '{tm: 1'b0, frames: 3, exp_req: 72, exp_href: 9, exp_vsync: 66};
        vecs[3] = '{tm: 1'b1, frames: 2, exp_req: 0,  exp_href: 6, exp_vsync: 44};

        rst_n     = 1'b0;
        tx_en     = 1'b0;
        test_mode = 1'b0;
        #1;
        check("rst_vsync", 32'(cmos_vsync), 0);
        check("rst_href", 32'(cmos_href), 0);
        check("rst_dout", 32'(cmos_dout), 0);
        check("rst_req", 32'(pixel_req), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk_cmos);
        rst_n = 1'b1;

        repeat (200) @(negedge clk_cmos);
        check("idle_req", req_total, 0);
        check("idle_vsync", vsync_cycles, 0);
        check("idle_href", href_rises, 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_frame_cnt", 32'(frame_cnt), 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // tx_en dropped during the second active line: the frame must still complete.
        @(negedge clk_cmos);
        r0  = req_total;
        h0  = href_rises;
        fc0 = frame_cnt;
        test_mode = 1'b0;
        tx_en     = 1'b1;
        waited = 0;
        while (href_rises < h0 + 2 && waited < 400) begin
            @(negedge clk_cmos);
            waited++;
        end
        check("drop_reached_line2", 32'(waited < 400), 1);
        repeat (3) @(negedge clk_cmos);
        tx_en  = 1'b0;
        waited = 0;
        while (busy && waited < 400) begin
            @(negedge clk_cmos);
            waited++;
        end
        check("drop_went_idle", 32'(busy), 0);
        repeat (5) @(negedge clk_cmos);
        check("drop_href_pulses", href_rises - h0, 3);
        check("drop_req_count", req_total - r0, 24);
        check("drop_frame_cnt", 32'(frame_cnt), 32'(8'(fc0 + 8'd1)));
        check("drop_bytes_left", 32'(exp_q.size()), 0);

        // Reset asserted mid-href, then a clean frame afterwards.
        @(negedge clk_cmos);
        tx_en  = 1'b1;
        waited = 0;
        while (!cmos_href && waited < 400) begin
            @(negedge clk_cmos);
            waited++;
        end
        check("rst_reached_href", 32'(cmos_href), 1);
        repeat (3) @(negedge clk_cmos);
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(cmos_dout), 0);
        check("async_rst_href", 32'(cmos_href), 0);
        check("async_rst_vsync", 32'(cmos_vsync), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 0);
        repeat (3) @(negedge clk_cmos);
        r0  = req_total;
        h0  = href_rises;
        vs0 = vsync_cycles;
        rst_n = 1'b1;
        repeat (FRAME_LEN - 10) @(negedge clk_cmos);
        tx_en = 1'b0;
        repeat (20) @(negedge clk_cmos);
        check("post_rst_href_pulses", href_rises - h0, 3);
        check("post_rst_req_count", req_total - r0, 24);
        check("post_rst_vsync", vsync_cycles - vs0, 22);
        check("post_rst_frame_cnt", 32'(frame_cnt), 1);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_bytes_left", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
